// File: rtl/redmule_job_launcher.sv
// redmule_job_launcher: programs RedMulE jobs over the HWPE peripheral port (acquire, write job regs, trigger, wait event)
// Ports: clk_i/rst_ni/clear_i; job_valid_i/job_ready_o/job_regs_i job source; evt_i completion event;
//        busy_o/job_done_o/job_id_o status; req_o/gnt_i/add_o/wen_o/be_o/data_o/id_o request; r_valid_i/r_data_i/r_id_i response
module redmule_job_launcher #(
  parameter int unsigned         ID_WIDTH    = 8,
  parameter int unsigned         N_JOB_REGS  = 10,
  parameter logic [31:0]         BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned         RETRY_WAIT  = 16,
  parameter logic [ID_WIDTH-1:0] LAUNCHER_ID = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     job_valid_i,
  output logic                     job_ready_o,
  input  logic [N_JOB_REGS*32-1:0] job_regs_i,
  input  logic                     evt_i,
  output logic                     busy_o,
  output logic                     job_done_o,
  output logic [7:0]               job_id_o,
  output logic                     req_o,
  input  logic                     gnt_i,
  output logic [31:0]              add_o,
  output logic                     wen_o,
  output logic [3:0]               be_o,
  output logic [31:0]              data_o,
  output logic [ID_WIDTH-1:0]      id_o,
  input  logic                     r_valid_i,
  input  logic [31:0]              r_data_i,
  input  logic [ID_WIDTH-1:0]      r_id_i
);
  localparam int unsigned CW = $clog2(RETRY_WAIT + 1);
  localparam logic [4:0] LAST = 5'(N_JOB_REGS - 1);
  typedef enum logic [3:0] {IDLE, ACQ_REQ, ACQ_RSP, BACKOFF, WR_REQ, WR_RSP, TRIG_REQ, TRIG_RSP, WAIT_EVT, DONE} state_t;
  state_t                   r_state, w_next, w_acq_nxt, w_wr_nxt;
  logic [N_JOB_REGS*32-1:0] r_regs;
  logic [4:0]               r_idx;
  logic [CW-1:0]            r_cnt;
  logic [7:0]               r_job_id;
  logic                     w_acq_rsp, w_wr_rsp, w_trig_rsp, w_unused;
  // a grant with a same-cycle response counts as the response, skipping the *_RSP wait
  assign w_acq_rsp  = r_valid_i && (r_state == ACQ_RSP  || (r_state == ACQ_REQ  && gnt_i));
  assign w_wr_rsp   = r_valid_i && (r_state == WR_RSP   || (r_state == WR_REQ   && gnt_i));
  assign w_trig_rsp = r_valid_i && (r_state == TRIG_RSP || (r_state == TRIG_REQ && gnt_i));
  assign w_acq_nxt  = r_data_i[31] ? BACKOFF : WR_REQ;
  assign w_wr_nxt   = r_idx == LAST ? TRIG_REQ : WR_REQ;
  assign w_unused   = ^{r_data_i[30:8], r_id_i};
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = job_valid_i ? ACQ_REQ : IDLE;
      ACQ_REQ:  w_next = w_acq_rsp ? w_acq_nxt : gnt_i ? ACQ_RSP : ACQ_REQ;
      ACQ_RSP:  w_next = w_acq_rsp ? w_acq_nxt : ACQ_RSP;
      BACKOFF:  w_next = r_cnt == CW'(1) ? ACQ_REQ : BACKOFF;
      WR_REQ:   w_next = w_wr_rsp ? w_wr_nxt : gnt_i ? WR_RSP : WR_REQ;
      WR_RSP:   w_next = w_wr_rsp ? w_wr_nxt : WR_RSP;
      TRIG_REQ: w_next = w_trig_rsp ? WAIT_EVT : gnt_i ? TRIG_RSP : TRIG_REQ;
      TRIG_RSP: w_next = w_trig_rsp ? WAIT_EVT : TRIG_RSP;
      WAIT_EVT: w_next = evt_i ? DONE : WAIT_EVT;
      default:  w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_regs   <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_job_id <= '0;
    end else if (clear_i) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && job_valid_i) r_regs <= job_regs_i;
      if (w_acq_rsp && r_data_i[31]) r_cnt <= CW'(RETRY_WAIT);
      if (w_acq_rsp && !r_data_i[31]) begin
        r_job_id <= r_data_i[7:0];
        r_idx    <= '0;
      end
      if (r_state == BACKOFF) r_cnt <= r_cnt - CW'(1);
      // the latched descriptor shifts down so the current word is always at the bottom
      if (w_wr_rsp) begin
        r_regs <= r_regs >> 32;
        r_idx  <= r_idx == LAST ? r_idx : r_idx + 5'd1;
      end
    end
  end
  assign req_o       = r_state inside {ACQ_REQ, WR_REQ, TRIG_REQ};
  assign add_o       = r_state == ACQ_REQ  ? BASE_ADDR + 32'h4 :
                       r_state == WR_REQ   ? BASE_ADDR + 32'h40 + {25'b0, r_idx, 2'b0} :
                       r_state == TRIG_REQ ? BASE_ADDR : 32'h0;
  assign wen_o       = r_state == ACQ_REQ;
  assign be_o        = req_o ? 4'hF : 4'h0;
  assign data_o      = r_state == WR_REQ ? r_regs[31:0] : 32'h0;
  assign id_o        = req_o ? LAUNCHER_ID : '0;
  assign job_ready_o = r_state == IDLE;
  assign busy_o      = !(r_state inside {IDLE, DONE});
  assign job_done_o  = r_state == DONE;
  assign job_id_o    = r_job_id;
endmodule

// File: tb/tb_redmule_job_launcher.sv
// tb_redmule_job_launcher: directed bench for redmule_job_launcher with a reactive peripheral slave
module tb_redmule_job_launcher;
  logic          clk_i = 0, rst_ni = 0, clear_i = 0, job_valid_i = 0, evt_i = 0;
  logic [319:0]  job_regs_i = '0;
  logic          job_ready_o, busy_o, job_done_o, req_o, wen_o;
  logic [7:0]    job_id_o, id_o, r_id_i = '0;
  logic          gnt_i = 0, r_valid_i = 0;
  logic [31:0]   add_o, data_o, r_data_i = '0;
  logic [3:0]    be_o;
  int            checks = 0, errors = 0, cyc = 0;
  int            stall_left = 0, late_lat = 1, evt_dly = 20, trig_cyc = -1, pend_cnt = 0;
  int            done_cnt = 0, done_cyc = 0, held50 = 0, acc = 0;
  logic [31:0]   stall_add = '1, late_add = '1, pend_data = '0, h_add, h_data;
  bit            zl = 0, spur_en = 0, held = 0;
  logic [31:0]   rd_q[$], t_add[$], t_data[$];
  bit            t_wen[$];
  int            t_cyc[$];
  logic [7:0]    done_ids[$];
  redmule_job_launcher dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
    .job_regs_i(job_regs_i), .evt_i(evt_i), .busy_o(busy_o), .job_done_o(job_done_o), .job_id_o(job_id_o),
    .req_o(req_o), .gnt_i(gnt_i), .add_o(add_o), .wen_o(wen_o), .be_o(be_o), .data_o(data_o), .id_o(id_o),
    .r_valid_i(r_valid_i), .r_data_i(r_data_i), .r_id_i(r_id_i)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    logic [31:0] rdat;
    rdat = 32'h0;
    @(posedge clk_i);
    #1;
    cyc++;
    if (job_done_o) begin
      done_cnt++;
      done_cyc = cyc;
      done_ids.push_back(job_id_o);
      chk("busy_at_done", busy_o, 1'b0);
    end
    if (held) begin
      chk("stall_req", req_o, 1'b1);
      chk("stall_add", add_o, h_add);
      chk("stall_data", data_o, h_data);
    end
    if (req_o && add_o == 32'h50) held50++;
    evt_i = (trig_cyc >= 0 && cyc == trig_cyc + evt_dly) || (spur_en && req_o && !wen_o && add_o == 32'h48);
    if (!zl) begin
      r_valid_i = pend_cnt == 1;
      r_data_i  = pend_cnt == 1 ? pend_data : 32'h0;
      if (pend_cnt > 0) pend_cnt--;
    end
    gnt_i = req_o && !(add_o == stall_add && stall_left > 0);
    if (req_o && !gnt_i) stall_left--;
    if (gnt_i) begin
      chk("be", be_o, 4'hF);
      chk("id", id_o, 8'h0);
      t_add.push_back(add_o);
      t_data.push_back(data_o);
      t_wen.push_back(wen_o);
      t_cyc.push_back(cyc);
      if (wen_o && rd_q.size() > 0) rdat = rd_q.pop_front();
      if (!wen_o && add_o == 32'h0) trig_cyc = cyc;
      if (!zl) begin
        pend_cnt  = add_o == late_add ? late_lat : 1;
        pend_data = rdat;
      end
    end
    if (zl) begin
      r_valid_i = gnt_i;
      r_data_i  = rdat;
    end
    held   = req_o && !gnt_i;
    h_add  = add_o;
    h_data = data_o;
  endtask
  task automatic clr_log();
    t_add.delete(); t_data.delete(); t_wen.delete(); t_cyc.delete(); done_ids.delete();
    done_cnt = 0; trig_cyc = -1; held50 = 0;
  endtask
  task automatic set_regs(input logic [31:0] base);
    for (int i = 0; i < 10; i++) job_regs_i[i*32 +: 32] = base + i;
  endtask
  task automatic start_job(input logic [31:0] base);
    int k = 0;
    while (!job_ready_o && k < 100) begin tick(); k++; end
    set_regs(base);
    job_valid_i = 1;
    tick();
    job_valid_i = 0;
    acc = cyc;
    chk("accept_busy", busy_o, 1'b1);
  endtask
  task automatic wait_done(input int n);
    int k = 0;
    while (done_cnt < n && k < 1000) begin tick(); k++; end
    chk("done_in_time", done_cnt >= n, 1'b1);
  endtask
  task automatic chk_job(input int off, input int nacq, input logic [31:0] base);
    int k;
    for (int i = 0; i < nacq; i++) begin
      chk("acq_add", t_add[off+i], 32'h4);
      chk("acq_wen", t_wen[off+i], 1'b1);
    end
    for (int i = 0; i < 10; i++) begin
      k = off + nacq + i;
      chk("wr_add", t_add[k], 32'h40 + 4*i);
      chk("wr_data", t_data[k], base + i);
      chk("wr_wen", t_wen[k], 1'b0);
    end
    k = off + nacq + 10;
    chk("trig_add", t_add[k], 32'h0);
    chk("trig_data", t_data[k], 32'h0);
    chk("trig_wen", t_wen[k], 1'b0);
  endtask
  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ready", job_ready_o, 1'b1);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", job_done_o, 1'b0);
    chk("rst_req", req_o, 1'b0);
    chk("rst_add", add_o, 32'h0);
    chk("rst_wen", wen_o, 1'b0);
    chk("rst_be", be_o, 4'h0);
    chk("rst_data", data_o, 32'h0);
    chk("rst_jobid", job_id_o, 8'h0);
    rst_ni = 1;
    tick();
    clr_log(); rd_q = {32'h3};
    start_job(32'hA000_0000);
    wait_done(1);
    chk("basic_ntx", t_add.size(), 12);
    chk_job(0, 1, 32'hA000_0000);
    chk("basic_ndone", done_cnt, 1);
    chk("basic_id", done_ids[0], 8'h3);
    chk("basic_latency", done_cyc - acc, 43);
    tick();
    chk("basic_once", done_cnt, 1);
    chk("basic_jobid_held", job_id_o, 8'h3);
    clr_log(); rd_q = {32'h7}; stall_add = 32'h50; stall_left = 5;
    start_job(32'h1111_0000);
    wait_done(1);
    stall_add = '1;
    chk("stall_ntx", t_add.size(), 12);
    chk("stall_cycles", held50, 6);
    chk_job(0, 1, 32'h1111_0000);
    chk("stall_id", done_ids[0], 8'h7);
    clr_log(); rd_q = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1};
    start_job(32'h2222_0000);
    wait_done(1);
    chk("retry_ntx", t_add.size(), 14);
    chk_job(0, 3, 32'h2222_0000);
    chk("retry_gap1", t_cyc[1] - t_cyc[0], 18);
    chk("retry_gap2", t_cyc[2] - t_cyc[1], 18);
    chk("retry_id", done_ids[0], 8'h1);
    clr_log(); rd_q = {32'h2, 32'h4}; late_add = 32'h58; late_lat = 3;
    start_job(32'h3333_0000);
    for (int k = 0; k < 100 && !(gnt_i && add_o == 32'h58); k++) tick();
    chk("clr_reach", gnt_i && add_o == 32'h58, 1'b1);
    tick();
    chk("clr_in_rsp", busy_o && !req_o, 1'b1);
    clear_i = 1;
    tick();
    clear_i = 0;
    chk("clr_ready", job_ready_o, 1'b1);
    chk("clr_busy", busy_o, 1'b0);
    chk("clr_req", req_o, 1'b0);
    chk("clr_done", job_done_o, 1'b0);
    tick();
    chk("clr_late_rv", r_valid_i, 1'b1);
    tick();
    late_add = '1;
    chk("clr_late_ignored", job_ready_o && !req_o, 1'b1);
    chk("clr_ntx", t_add.size(), 8);
    chk("clr_nodone", done_cnt, 0);
    start_job(32'h4444_0000);
    wait_done(1);
    chk("clr_restart_ntx", t_add.size(), 20);
    chk_job(8, 1, 32'h4444_0000);
    chk("clr_restart_id", done_ids[0], 8'h4);
    clr_log(); rd_q = {32'h5, 32'h6};
    start_job(32'hB000_0000);
    job_valid_i = 1;
    set_regs(32'hC000_0000);
    wait_done(1);
    for (int k = 0; k < 10 && !busy_o; k++) tick();
    job_valid_i = 0;
    chk("b2b_accept_cyc", cyc, done_cyc + 2);
    wait_done(2);
    chk("b2b_ntx", t_add.size(), 24);
    chk_job(0, 1, 32'hB000_0000);
    chk_job(12, 1, 32'hC000_0000);
    chk("b2b_acq2_after_done", t_cyc[12] > t_cyc[11] + 20, 1'b1);
    chk("b2b_id1", done_ids[0], 8'h5);
    chk("b2b_id2", done_ids[1], 8'h6);
    clr_log(); rd_q = {32'h9}; spur_en = 1;
    start_job(32'h5555_0000);
    wait_done(1);
    spur_en = 0;
    chk_job(0, 1, 32'h5555_0000);
    chk("spur_ndone", done_cnt, 1);
    chk("spur_done_cyc", done_cyc, trig_cyc + 21);
    clr_log(); rd_q = {32'h0000_00AB}; zl = 1; evt_dly = 3;
    start_job(32'h6666_0000);
    wait_done(1);
    zl = 0; r_valid_i = 0;
    chk("zl_ntx", t_add.size(), 12);
    chk_job(0, 1, 32'h6666_0000);
    chk("zl_latency", done_cyc - acc, 15);
    chk("zl_id", done_ids[0], 8'hAB);
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
